// File: rtl/seq_alu_pkg.sv
// ============================================================================
// Module      : seq_alu_pkg
// Description : Shared definitions for the sequential ALU: opcode width,
//               opcode encodings, FSM state encoding and a small opcode helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_alu_pkg;

    localparam int ALU_OPRN_W = 6;

    localparam logic [ALU_OPRN_W-1:0] ALU_ADD = 6'd1;
    localparam logic [ALU_OPRN_W-1:0] ALU_SUB = 6'd2;
    localparam logic [ALU_OPRN_W-1:0] ALU_MUL = 6'd3;
    localparam logic [ALU_OPRN_W-1:0] ALU_SRL = 6'd4;
    localparam logic [ALU_OPRN_W-1:0] ALU_SLL = 6'd5;
    localparam logic [ALU_OPRN_W-1:0] ALU_AND = 6'd6;
    localparam logic [ALU_OPRN_W-1:0] ALU_OR  = 6'd7;
    localparam logic [ALU_OPRN_W-1:0] ALU_NOR = 6'd8;
    localparam logic [ALU_OPRN_W-1:0] ALU_SLT = 6'd9;

    // Control FSM states, explicitly encoded in two bits.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic logic is_mul_op(input logic [ALU_OPRN_W-1:0] oprn);
        return (oprn == ALU_MUL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_alu_mult_core.sv
// ============================================================================
// Module      : seq_alu_mult_core
// Description : Iterative signed shift-add multiplier datapath. Holds the
//               operand magnitudes, the accumulator, the result sign and the
//               bit counter. Sequenced by the seq_alu FSM through go/step/fin.
//               With SEQ_ALU_MULT_HI_EN defined the accumulator is 2*DATA_W
//               wide and the upper product half is exported on o_prod_hi;
//               otherwise only the low DATA_W bits are kept.
// Ports       : clk        - clock, rising edge
//               rst_n      - synchronous active-low reset
//               i_go       - latch operands, clear accumulator and counter
//               i_step     - perform one partial-product step
//               i_fin      - final step taken; return datapath to zero
//               i_op1/2    - signed operands (sampled on i_go)
//               o_last     - current step is the last one (bit DATA_W-1)
//               o_prod_lo  - signed product low half including current step
//               o_prod_hi  - signed product high half (SEQ_ALU_MULT_HI_EN)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu_mult_core #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_go,
    input  logic              i_step,
    input  logic              i_fin,
    input  logic [DATA_W-1:0] i_op1,
    input  logic [DATA_W-1:0] i_op2,
    output logic              o_last,
    output logic [DATA_W-1:0] o_prod_lo
`ifdef SEQ_ALU_MULT_HI_EN
    ,
    output logic [DATA_W-1:0] o_prod_hi
`endif
);

`ifdef SEQ_ALU_MULT_HI_EN
    localparam int ACC_W = 2 * DATA_W;
`else
    // The low word of a negated value depends only on the low word of the
    // magnitude, so a DATA_W accumulator still yields an exact low half.
    localparam int ACC_W = DATA_W;
`endif

    logic [ACC_W-1:0]   r_mcand;
    logic [ACC_W-1:0]   r_acc;
    logic [DATA_W-1:0]  r_mplier;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_neg;

    logic [DATA_W-1:0]  w_mag1;
    logic [DATA_W-1:0]  w_mag2;
    logic [ACC_W-1:0]   w_mcand_init;
    logic [ACC_W-1:0]   w_acc_next;
    logic [ACC_W-1:0]   w_prod;

    // Magnitudes: MIN_INT negates to itself, which read unsigned is exactly
    // 2^(DATA_W-1), so no extra bit is needed.
    always_comb begin
        w_mag1       = i_op1[DATA_W-1] ? -i_op1 : i_op1;
        w_mag2       = i_op2[DATA_W-1] ? -i_op2 : i_op2;
        w_mcand_init = '0;
        w_mcand_init[DATA_W-1:0] = w_mag1;
    end

    // Accumulator value after the current step; the product is taken from
    // this so the FSM can register the result on the final step edge.
    always_comb begin
        w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
        w_prod     = r_neg ? -w_acc_next : w_acc_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else if (i_go) begin
            r_mcand  <= w_mcand_init;
            r_mplier <= w_mag2;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_neg    <= i_op1[DATA_W-1] ^ i_op2[DATA_W-1];
        end else if (i_fin) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
        end else if (i_step) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + {{(SHAMT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_last    = (r_cnt == SHAMT_W'(DATA_W - 1));
    assign o_prod_lo = w_prod[DATA_W-1:0];
`ifdef SEQ_ALU_MULT_HI_EN
    assign o_prod_hi = w_prod[ACC_W-1:DATA_W];
`endif

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// Module      : seq_alu
// Description : Multi-cycle ALU with a START/BUSY/DONE handshake. Single-cycle
//               ops (add, sub, srl, sll, and, or, nor, slt) complete one cycle
//               after accept; MUL runs a DATA_W-step shift-add in
//               seq_alu_mult_core and completes DATA_W+1 cycles after accept.
//               Optional feature macro: SEQ_ALU_MULT_HI_EN adds the HI port
//               carrying the upper half of the signed product.
// Ports       : CLK   - clock, rising edge
//               RST   - synchronous active-low reset
//               START - request, accepted only in IDLE
//               OPRN  - opcode (1 add .. 9 slt; others yield 0)
//               OP1   - operand 1
//               OP2   - operand 2 (shift amount for shifts)
//               BUSY  - MUL in progress
//               DONE  - one-cycle result-valid pulse
//               OUT   - result, held until the next DONE
//               ZERO  - OUT == 0
//               HI    - upper product half (SEQ_ALU_MULT_HI_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [ALU_OPRN_W-1:0] OPRN,
    input  logic [DATA_W-1:0]     OP1,
    input  logic [DATA_W-1:0]     OP2,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_W-1:0]     OUT,
    output logic                  ZERO
`ifdef SEQ_ALU_MULT_HI_EN
    ,
    output logic [DATA_W-1:0]     HI
`endif
);

    state_t             r_state;

    logic [DATA_W-1:0]  w_alu_res;
    logic               w_shamt_ovf;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_accept;
    logic               w_mul_go;
    logic               w_mul_step;
    logic               w_mul_fin;
    logic               w_mul_last;
    logic [DATA_W-1:0]  w_prod_lo;
`ifdef SEQ_ALU_MULT_HI_EN
    logic [DATA_W-1:0]  w_prod_hi;
`endif

    // ------------------------------------------------------------------
    // Single-cycle ops, evaluated on the operands present at accept; the
    // result is registered on the accept edge so later input changes are
    // irrelevant.
    // ------------------------------------------------------------------
    always_comb begin
        w_shamt     = OP2[SHAMT_W-1:0];
        w_shamt_ovf = |OP2[DATA_W-1:SHAMT_W];
        w_alu_res   = '0;
        case (OPRN)
            ALU_ADD: w_alu_res = OP1 + OP2;
            ALU_SUB: w_alu_res = OP1 - OP2;
            ALU_SRL: w_alu_res = w_shamt_ovf ? '0 : (OP1 >> w_shamt);
            ALU_SLL: w_alu_res = w_shamt_ovf ? '0 : (OP1 << w_shamt);
            ALU_AND: w_alu_res = OP1 & OP2;
            ALU_OR:  w_alu_res = OP1 | OP2;
            ALU_NOR: w_alu_res = ~(OP1 | OP2);
            ALU_SLT: w_alu_res = {{(DATA_W-1){1'b0}}, ($signed(OP1) < $signed(OP2))};
            default: w_alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Multiplier sequencing
    // ------------------------------------------------------------------
    assign w_accept   = (r_state == ST_IDLE) && START;
    assign w_mul_go   = w_accept && is_mul_op(OPRN);
    assign w_mul_step = (r_state == ST_MUL);
    assign w_mul_fin  = w_mul_step && w_mul_last;

    seq_alu_mult_core #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_mult_core (
        .clk       (CLK),
        .rst_n     (RST),
        .i_go      (w_mul_go),
        .i_step    (w_mul_step),
        .i_fin     (w_mul_fin),
        .i_op1     (OP1),
        .i_op2     (OP2),
        .o_last    (w_mul_last),
        .o_prod_lo (w_prod_lo)
`ifdef SEQ_ALU_MULT_HI_EN
        ,
        .o_prod_hi (w_prod_hi)
`endif
    );

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. DONE is raised on the edge that
    // enters FIN, so it is high exactly for the FIN cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            OUT     <= '0;
            ZERO    <= 1'b1;
`ifdef SEQ_ALU_MULT_HI_EN
            HI      <= '0;
`endif
        end else begin
            DONE <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        if (is_mul_op(OPRN)) begin
                            r_state <= ST_MUL;
                            BUSY    <= 1'b1;
                        end else begin
                            r_state <= ST_FIN;
                            DONE    <= 1'b1;
                            OUT     <= w_alu_res;
                            ZERO    <= (w_alu_res == '0);
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_last) begin
                        r_state <= ST_FIN;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                        OUT     <= w_prod_lo;
                        ZERO    <= (w_prod_lo == '0);
`ifdef SEQ_ALU_MULT_HI_EN
                        HI      <= w_prod_hi;
`endif
                    end
                end
                ST_FIN: begin
                    // START here is deliberately dropped.
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// Module      : tb_seq_alu
// Description : Self-checking bench for seq_alu: directed vector table,
//               randomized ops against a behavioural model, and hand-written
//               sequences for ignored STARTs and reset during MUL.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int W       = 32;
    localparam int MUL_LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [5:0]    oprn;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic          busy;
    logic          done;
    logic [W-1:0]  out;
    logic          zero;
`ifdef SEQ_ALU_MULT_HI_EN
    logic [W-1:0]  hi;
`endif

    int            n_checks = 0;
    int            n_errors = 0;
    logic [W-1:0]  exp_hi   = '0;

    seq_alu #(.DATA_W(W), .SHAMT_W(5)) dut (
        .CLK   (clk),
        .RST   (rst_n),
        .START (start),
        .OPRN  (oprn),
        .OP1   (op1),
        .OP2   (op2),
        .BUSY  (busy),
        .DONE  (done),
        .OUT   (out),
        .ZERO  (zero)
`ifdef SEQ_ALU_MULT_HI_EN
        ,
        .HI    (hi)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [5:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] out;
        logic         zero;
        int           lat;
        logic [W-1:0] hi;
    } vec_t;

    vec_t vt[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain arithmetic on 64-bit integers.
    function automatic void model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi_o, output int lat);
        longint p;
        lo   = '0;
        hi_o = '0;
        lat  = 1;
        case (op)
            6'd1: lo = a + b;
            6'd2: lo = a - b;
            6'd3: begin
                p    = longint'($signed(a)) * longint'($signed(b));
                lo   = p[31:0];
                hi_o = p[63:32];
                lat  = MUL_LAT;
            end
            6'd4: lo = (b >= W) ? '0 : (a >> b);
            6'd5: lo = (b >= W) ? '0 : (a << b);
            6'd6: lo = a & b;
            6'd7: lo = a | b;
            6'd8: lo = ~(a | b);
            6'd9: lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: lo = '0;
        endcase
    endfunction

    // Issue one op, scramble the inputs after accept, wait for DONE and
    // check latency, BUSY profile, result, ZERO, HI and the one-cycle pulse.
    task automatic run_op(input string name, input logic [5:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e_out, input logic e_zero,
                          input int e_lat, input logic [W-1:0] hi_new);
        int   cyc;
        logic busy_ok;
        if (e_lat == MUL_LAT) exp_hi = hi_new;
        oprn  = op;
        op1   = a;
        op2   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op1   = $urandom;
        op2   = $urandom;
        oprn  = 6'($urandom_range(0, 63));
        cyc     = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 80) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(e_lat));
        if (e_lat == MUL_LAT) check({name, " busy_during"}, 64'(busy_ok), 64'd1);
        check({name, " out"}, 64'(out), 64'(e_out));
        check({name, " zero"}, 64'(zero), 64'(e_zero));
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
`ifdef SEQ_ALU_MULT_HI_EN
        check({name, " hi"}, 64'(hi), 64'(exp_hi));
`endif
        tick();
        check({name, " done_pulse"}, 64'(done), 64'd0);
        check({name, " out_hold"}, 64'(out), 64'(e_out));
    endtask

    initial begin
        int           cyc;
        logic         saw_done;
        logic [5:0]   r_op;
        logic [W-1:0] r_a, r_b, r_lo, r_hi;
        int           r_lat;

        vt[0]  = '{6'd1,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1,       32'h0};
        vt[1]  = '{6'd2,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1,       32'h0};
        vt[2]  = '{6'd9,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1,       32'h0};
        vt[3]  = '{6'd3,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB, 1'b0, MUL_LAT, 32'hFFFF_FFFF};
        vt[4]  = '{6'd5,  32'h0000_0001, 32'd31,        32'h8000_0000, 1'b0, 1,       32'h0};
        vt[5]  = '{6'd4,  32'h8000_0000, 32'd32,        32'h0000_0000, 1'b1, 1,       32'h0};
        vt[6]  = '{6'd4,  32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 1,       32'h0};
        vt[7]  = '{6'h2A, 32'h0000_DEAD, 32'h0000_BEEF, 32'h0000_0000, 1'b1, 1,       32'h0};
        vt[8]  = '{6'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1,       32'h0};
        vt[9]  = '{6'd7,  32'h0F0F_0000, 32'h0000_F0F0, 32'h0F0F_F0F0, 1'b0, 1,       32'h0};
        vt[10] = '{6'd8,  32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1,       32'h0};
        vt[11] = '{6'd3,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, MUL_LAT, 32'h4000_0000};
        vt[12] = '{6'd9,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1,       32'h0};
        vt[13] = '{6'd5,  32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b1, 1,       32'h0};
        vt[14] = '{6'd3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, MUL_LAT, 32'h0000_0000};
        vt[15] = '{6'd3,  32'h7FFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0, MUL_LAT, 32'h0000_0000};
        vt[16] = '{6'd1,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1,       32'h0};

        rst_n = 1'b0;
        start = 1'b0;
        oprn  = '0;
        op1   = '0;
        op2   = '0;
        repeat (3) tick();
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset out",  64'(out),  64'd0);
        check("reset zero", 64'(zero), 64'd1);
`ifdef SEQ_ALU_MULT_HI_EN
        check("reset hi",   64'(hi),   64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
                   vt[i].out, vt[i].zero, vt[i].lat, vt[i].hi);
        end

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            r_op = 6'($urandom_range(0, 12));
            r_a  = $urandom;
            r_b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            model(r_op, r_a, r_b, r_lo, r_hi, r_lat);
            run_op($sformatf("rnd%0d_op%0d", i, r_op), r_op, r_a, r_b,
                   r_lo, (r_lo == '0), r_lat, r_hi);
        end

        // START during MUL and during FIN is ignored
        exp_hi = '0;
        oprn   = 6'd3;
        op1    = 32'd5;
        op2    = 32'd6;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cyc    = 1;
        while (!done && cyc < 80) begin
            start = (cyc == 5) || (cyc == 6);
            oprn  = 6'd1;
            op1   = 32'd1;
            op2   = 32'd1;
            tick();
            cyc++;
        end
        start = 1'b0;
        check("ign_busy latency", 64'(cyc), 64'(MUL_LAT));
        check("ign_busy out",     64'(out), 64'd30);
        check("ign_busy zero",    64'(zero), 64'd0);
`ifdef SEQ_ALU_MULT_HI_EN
        check("ign_busy hi",      64'(hi), 64'd0);
`endif
        oprn  = 6'd1;
        op1   = 32'd2;
        op2   = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_fin done", 64'(done), 64'd0);
        check("ign_fin busy", 64'(busy), 64'd0);
        check("ign_fin out",  64'(out),  64'd30);
        tick();
        check("ign_fin no_late_done", 64'(done), 64'd0);
        check("ign_fin out_hold",     64'(out),  64'd30);
        run_op("after_fin_add", 6'd1, 32'd2, 32'd2, 32'd4, 1'b0, 1, 32'h0);

        // Reset in the middle of a MUL
        run_op("pre_rst_add", 6'd1, 32'd5, 32'd6, 32'd11, 1'b0, 1, 32'h0);
        oprn  = 6'd3;
        op1   = 32'hFFFF_FFFD;
        op2   = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 10) begin
            tick();
            cyc++;
        end
        check("mid_rst busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_hi = '0;
        check("mid_rst busy", 64'(busy), 64'd0);
        check("mid_rst out",  64'(out),  64'd0);
        check("mid_rst zero", 64'(zero), 64'd1);
        check("mid_rst done", 64'(done), 64'd0);
`ifdef SEQ_ALU_MULT_HI_EN
        check("mid_rst hi",   64'(hi),   64'd0);
`endif
        saw_done = 1'b0;
        repeat (40) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        check("mid_rst no_done", 64'(saw_done), 64'd0);
        run_op("post_rst_mul", 6'd3, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b0, MUL_LAT, 32'hFFFF_FFFF);
        run_op("post_rst_undef", 6'h2A, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
